// File: rtl/task_dispatcher.sv
// Round-robin priority dispatcher: scans task slots one per cycle, issues Execute,
// waits a fixed slice, then issues Finish on a registered valid/ready op bus.
module task_dispatcher #(
    parameter int         NUM_TASKS    = 4,
    parameter int         SLICE_CYCLES = 8,
    parameter logic [3:0] EXE_OP       = 4'b0111,
    parameter logic [3:0] FIN_OP       = 4'b1000
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    EN,
    input  logic [16*NUM_TASKS-1:0] in_tasks,
    output logic [15:0]             out_op,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [7:0]              cur_task,
    output logic                    busy,
    output logic [2:0]              dbg_state_o
);

    localparam int IDX_W = (NUM_TASKS > 1) ? $clog2(NUM_TASKS) : 1;
    localparam int CNT_W = (SLICE_CYCLES > 1) ? $clog2(SLICE_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SCAN = 3'd1,
        S_EXE  = 3'd2,
        S_RUN  = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    // Valid/ready: a command transfers on a rising edge where out_valid and out_ready
    // are both 1; out_valid and out_op hold unchanged until that edge (or reset).

    state_t             state_q,      state_d;
    logic [IDX_W-1:0]   scan_idx_q,   scan_idx_d;
    logic [IDX_W-1:0]   scan_cnt_q,   scan_cnt_d;
    logic [IDX_W-1:0]   rr_ptr_q,     rr_ptr_d;
    logic               best_valid_q, best_valid_d;
    logic [7:0]         best_id_q,    best_id_d;
    logic [7:0]         best_prio_q,  best_prio_d;
    logic [IDX_W-1:0]   best_slot_q,  best_slot_d;
    logic [CNT_W-1:0]   cnt_q,        cnt_d;
    logic [7:0]         cur_task_q,   cur_task_d;
    logic               out_valid_q,  out_valid_d;
    logic [15:0]        out_op_q,     out_op_d;

    logic [15:0]        slot_w [NUM_TASKS];
    logic [15:0]        slot_word;
    logic               take;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
        wrap_inc = (v == IDX_W'(NUM_TASKS - 1)) ? '0 : v + IDX_W'(1);
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_TASKS; i++) begin
            slot_w[i] = in_tasks[i*16 +: 16];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IDLE;
            scan_idx_q   <= '0;
            scan_cnt_q   <= '0;
            rr_ptr_q     <= '0;
            best_valid_q <= 1'b0;
            best_id_q    <= '0;
            best_prio_q  <= '0;
            best_slot_q  <= '0;
            cnt_q        <= '0;
            cur_task_q   <= '0;
            out_valid_q  <= 1'b0;
            out_op_q     <= '0;
        end else begin
            state_q      <= state_d;
            scan_idx_q   <= scan_idx_d;
            scan_cnt_q   <= scan_cnt_d;
            rr_ptr_q     <= rr_ptr_d;
            best_valid_q <= best_valid_d;
            best_id_q    <= best_id_d;
            best_prio_q  <= best_prio_d;
            best_slot_q  <= best_slot_d;
            cnt_q        <= cnt_d;
            cur_task_q   <= cur_task_d;
            out_valid_q  <= out_valid_d;
            out_op_q     <= out_op_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        scan_idx_d   = scan_idx_q;
        scan_cnt_d   = scan_cnt_q;
        rr_ptr_d     = rr_ptr_q;
        best_valid_d = best_valid_q;
        best_id_d    = best_id_q;
        best_prio_d  = best_prio_q;
        best_slot_d  = best_slot_q;
        cnt_d        = cnt_q;
        cur_task_d   = cur_task_q;
        out_valid_d  = 1'b0;
        out_op_d     = '0;

        slot_word = slot_w[scan_idx_q];
        // Strict compare: the earliest slot in rotated order keeps a tie.
        take = (slot_word != 16'h0000) && (!best_valid_q || (slot_word[7:0] > best_prio_q));

        case (state_q)
            S_IDLE: begin
                if (EN) begin
                    state_d      = S_SCAN;
                    scan_idx_d   = rr_ptr_q;
                    scan_cnt_d   = '0;
                    best_valid_d = 1'b0;
                end
            end
            S_SCAN: begin
                if (take) begin
                    best_valid_d = 1'b1;
                    best_id_d    = slot_word[15:8];
                    best_prio_d  = slot_word[7:0];
                    best_slot_d  = scan_idx_q;
                end
                scan_idx_d = wrap_inc(scan_idx_q);
                scan_cnt_d = scan_cnt_q + IDX_W'(1);
                if (scan_cnt_q == IDX_W'(NUM_TASKS - 1)) begin
                    scan_cnt_d = '0;
                    state_d    = best_valid_d ? S_EXE : S_IDLE;
                end
            end
            S_EXE: begin
                if (out_valid_q && out_ready) begin
                    cur_task_d = best_id_q;
                    rr_ptr_d   = wrap_inc(best_slot_q);
                    cnt_d      = CNT_W'(SLICE_CYCLES - 1);
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                if (cnt_q == '0) begin
                    state_d = S_FIN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_FIN: begin
                if (out_valid_q && out_ready) begin
                    cur_task_d = '0;
                    if (EN) begin
                        state_d      = S_SCAN;
                        scan_idx_d   = rr_ptr_q;
                        scan_cnt_d   = '0;
                        best_valid_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they align with it.
        out_valid_d = (state_d == S_EXE) || (state_d == S_FIN);
        case (state_d)
            S_EXE:   out_op_d = {4'h0, best_id_d[3:0], EXE_OP, 4'h0};
            S_FIN:   out_op_d = {4'h0, cur_task_d[3:0], FIN_OP, 4'h0};
            default: out_op_d = '0;
        endcase
    end

    assign out_op      = out_op_q;
    assign out_valid   = out_valid_q;
    assign cur_task    = cur_task_q;
    assign busy        = (state_q != S_IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_task_dispatcher.sv
// Bench for task_dispatcher: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against a transaction-level model.
module tb_task_dispatcher;

    localparam int NT    = 4;
    localparam int SLICE = 8;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              EN = 1'b0;
    logic              out_ready = 1'b0;
    logic [16*NT-1:0]  in_tasks = '0;
    logic [15:0]       out_op;
    logic              out_valid;
    logic [7:0]        cur_task;
    logic              busy;
    logic [2:0]        dbg_state;

    always #5 CLK = ~CLK;

    task_dispatcher #(.NUM_TASKS(NT), .SLICE_CYCLES(SLICE)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .EN          (EN),
        .in_tasks    (in_tasks),
        .out_op      (out_op),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .cur_task    (cur_task),
        .busy        (busy),
        .dbg_state_o (dbg_state)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0]      exp_q[$];
    logic             m_valid = 1'b0;
    logic             m_busy = 1'b0;
    logic [15:0]      m_op = '0;
    logic [7:0]       m_cur = '0;
    int               m_rr = 0;
    logic             en_s = 1'b0, rdy_s = 1'b0, rst_s = 1'b0;
    logic [16*NT-1:0] tasks_s = '0;

    task automatic tick();
        @(posedge CLK);
        en_s    = EN;
        rdy_s   = out_ready;
        rst_s   = RST;
        tasks_s = in_tasks;
    endtask

    // Returns whenever a reset edge is seen; the caller restores the reset view.
    task automatic model_body();
        logic [15:0] w;
        int          best;
        int          s;
        logic [7:0]  bprio;
        logic [7:0]  bid;
        bit          go;
        forever begin
            do begin
                tick();
                if (rst_s) return;
            end while (!en_s);
            go = 1'b1;
            while (go) begin
                m_busy = 1'b1;
                best   = -1;
                bprio  = '0;
                bid    = '0;
                for (int k = 0; k < NT; k++) begin
                    tick();
                    if (rst_s) return;
                    s = (m_rr + k) % NT;
                    w = tasks_s[s*16 +: 16];
                    if (w != 16'h0 && (best < 0 || w[7:0] > bprio)) begin
                        best  = s;
                        bprio = w[7:0];
                        bid   = w[15:8];
                    end
                end
                if (best < 0) begin
                    m_busy = 1'b0;
                    go     = 1'b0;
                end else begin
                    m_valid = 1'b1;
                    m_op    = {4'h0, bid[3:0], 4'h7, 4'h0};
                    exp_q.push_back(m_op);
                    do begin
                        tick();
                        if (rst_s) return;
                    end while (!rdy_s);
                    m_valid = 1'b0;
                    m_cur   = bid;
                    m_rr    = (best + 1) % NT;
                    repeat (SLICE) begin
                        tick();
                        if (rst_s) return;
                    end
                    m_valid = 1'b1;
                    m_op    = {4'h0, m_cur[3:0], 4'h8, 4'h0};
                    exp_q.push_back(m_op);
                    do begin
                        tick();
                        if (rst_s) return;
                    end while (!rdy_s);
                    m_valid = 1'b0;
                    m_cur   = '0;
                    if (!en_s) begin
                        m_busy = 1'b0;
                        go     = 1'b0;
                    end
                end
            end
        end
    endtask

    initial begin : model_proc
        forever begin
            m_valid = 1'b0;
            m_busy  = 1'b0;
            m_op    = '0;
            m_cur   = '0;
            m_rr    = 0;
            exp_q.delete();
            model_body();
        end
    end

    // ---------------- per-cycle compare ----------------
    logic chk_en = 1'b0;
    logic prev_v = 1'b0;

    always @(negedge CLK) begin
        if (chk_en) begin
            check("out_valid", 32'(out_valid), 32'(m_valid));
            check("busy", 32'(busy), 32'(m_busy));
            check("cur_task", 32'(cur_task), 32'(m_cur));
            if (m_valid || rst_s) check("out_op", 32'(out_op), 32'(m_op));
            if (out_valid && !prev_v) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_pop actual=cmd %h expected=no command t=%0t", out_op, $time);
                end else begin
                    check("sb_cmd", 32'(out_op), 32'(exp_q.pop_front()));
                end
            end
        end
        prev_v = out_valid;
    end

    // ---------------- driver helpers ----------------
    task automatic set_slots(input logic [15:0] s0, input logic [15:0] s1,
                             input logic [15:0] s2, input logic [15:0] s3);
        in_tasks = {s3, s2, s1, s0};
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        EN = 1'b0;
        out_ready = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // Counts falling edges until out_valid is seen high (bounded by max).
    task automatic wait_valid(input int max, output int n);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!out_valid && n < max);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    logic [15:0] seq3 [5];
    int n;
    int v_seen, b_lo, b_hi;

    initial begin : main
        seq3 = '{16'h0270, 16'h0280, 16'h0370, 16'h0380, 16'h0270};

        // Reset with garbage on the task bus
        in_tasks = {$urandom, $urandom};
        EN = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(negedge CLK);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_op", 32'(out_op), 32'h0);
        check("rst_cur", 32'(cur_task), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        chk_en = 1'b1;
        do_reset();

        // Single ready task in slot 2
        set_slots(16'h0000, 16'h0000, 16'h0703, 16'h0000);
        out_ready = 1'b1;
        EN = 1'b1;
        wait_valid(20, n);
        check("s2_latency", 32'(n), 32'd5);
        check("s2_exe_op", 32'(out_op), 32'h0770);
        @(negedge CLK);
        check("s2_cur_run", 32'(cur_task), 32'd7);
        wait_valid(20, n);
        check("s2_fin_gap", 32'(n), 32'd8);
        check("s2_fin_op", 32'(out_op), 32'h0780);
        @(negedge CLK);
        check("s2_cur_clr", 32'(cur_task), 32'd0);
        do_reset();

        // Priority with tie rotation
        set_slots(16'h0105, 16'h0209, 16'h0309, 16'h0402);
        out_ready = 1'b1;
        EN = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_valid(40, n);
            check("s3_seq", 32'(out_op), 32'(seq3[i]));
            @(negedge CLK);
        end
        do_reset();

        // Backpressure on Execute
        set_slots(16'h0105, 16'h0209, 16'h0309, 16'h0402);
        out_ready = 1'b0;
        EN = 1'b1;
        wait_valid(20, n);
        check("s4_latency", 32'(n), 32'd5);
        repeat (10) begin
            @(negedge CLK);
            check("s4_hold_valid", 32'(out_valid), 32'h1);
            check("s4_hold_op", 32'(out_op), 32'h0270);
        end
        out_ready = 1'b1;
        @(negedge CLK);
        check("s4_accepted", 32'(out_valid), 32'h0);
        wait_valid(20, n);
        check("s4_fin_gap", 32'(n), 32'd8);
        check("s4_fin_op", 32'(out_op), 32'h0280);
        do_reset();

        // Nothing ready: IDLE/SCAN alternate, 1 idle cycle per 5
        set_slots(16'h0, 16'h0, 16'h0, 16'h0);
        out_ready = 1'b1;
        EN = 1'b1;
        v_seen = 0;
        b_lo = 0;
        b_hi = 0;
        repeat (50) begin
            @(negedge CLK);
            if (out_valid) v_seen++;
            if (busy) b_hi++;
            else b_lo++;
        end
        check("s5_no_valid", 32'(v_seen), 32'd0);
        check("s5_busy_lo", 32'(b_lo), 32'd10);
        check("s5_busy_hi", 32'(b_hi), 32'd40);
        do_reset();

        // Reset in the third RUN cycle; next round restarts from slot 0
        set_slots(16'h0105, 16'h0209, 16'h0309, 16'h0402);
        out_ready = 1'b1;
        EN = 1'b1;
        wait_valid(20, n);
        check("s6_exe_op", 32'(out_op), 32'h0270);
        repeat (3) @(negedge CLK);
        check("s6_cur_run", 32'(cur_task), 32'd2);
        RST = 1'b1;
        @(negedge CLK);
        check("s6_rst_valid", 32'(out_valid), 32'h0);
        check("s6_rst_cur", 32'(cur_task), 32'h0);
        check("s6_rst_busy", 32'(busy), 32'h0);
        RST = 1'b0;
        wait_valid(20, n);
        check("s6_relatency", 32'(n), 32'd5);
        check("s6_restart_op", 32'(out_op), 32'h0270);
        do_reset();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK);
            for (int i = 0; i < NT; i++) begin
                if ($urandom_range(0, 4) == 0) begin
                    if ($urandom_range(0, 9) < 4) in_tasks[i*16 +: 16] = 16'h0;
                    else in_tasks[i*16 +: 16] = {8'($urandom), 8'($urandom_range(0, 3))};
                end
            end
            EN = ($urandom_range(0, 9) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            RST = ($urandom_range(0, 199) == 0);
        end
        @(negedge CLK);
        RST = 1'b0;
        EN = 1'b0;
        out_ready = 1'b1;
        repeat (30) @(negedge CLK);
        check("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
